// File: rtl/stream_pattern_pkg.sv
// rtl/stream_pattern_pkg.sv - shared types and helpers for stream_pattern_gen
package stream_pattern_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_CONST = 2'd1,
        MODE_IDX   = 2'd2
    } mode_t;

    localparam int MAX_BYTES = 64;

    // Byte enables for the final beat: low rem lanes, or every lane when rem is zero.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [31:0] rem, input int bytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            m[i] = (rem == 32'd0) ? (i < bytes) : (32'(i) < rem);
        return m;
    endfunction

endpackage

// File: rtl/pattern_fill.sv
// rtl/pattern_fill.sv - combinational tdata generator for one beat index
module pattern_fill
    import stream_pattern_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       mode,
    input  logic [7:0]       seed,
    input  logic [31:0]      beat,
    output logic [WIDTH-1:0] data
);

    localparam int BYTES = WIDTH / 8;
    localparam logic [7:0] BYTES8 = 8'(BYTES);

    logic [7:0] base;

    // Lane i of mode 0 is base + i; everything is modulo 256 by construction.
    assign base = seed + beat[7:0] * BYTES8;

    always_comb begin
        data = '0;
        for (int i = 0; i < BYTES; i++) begin
            case (mode)
                MODE_CONST: data[8*i +: 8] = seed;
                MODE_IDX:   data[8*i +: 8] = beat[8*(i%4) +: 8];
                default:    data[8*i +: 8] = base + 8'(i);
            endcase
        end
    end

endmodule

// File: rtl/stream_pattern_gen.sv
// rtl/stream_pattern_gen.sv - AXI4-Stream test-pattern source with ap_ctrl_hs control
module stream_pattern_gen
    import stream_pattern_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int PKT_W = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    output logic               ap_ready,
    output logic               ap_done,
    output logic               ap_idle,
    input  logic [1:0]         mode,
    input  logic [7:0]         seed,
    input  logic [31:0]        size,
    input  logic [PKT_W-1:0]   pkt_len,
    output logic [WIDTH-1:0]   tdata,
    output logic [WIDTH/8-1:0] tkeep,
    output logic               tvalid,
    output logic               tlast,
    input  logic               tready
);

    localparam int BYTES = WIDTH / 8;

    state_t             state, state_nxt;
    logic [1:0]         mode_r;
    logic [7:0]         seed_r;
    logic [PKT_W-1:0]   pkt_len_r, pkt_cnt, pkt_cnt_nxt;
    logic [31:0]        total_r, beat, beat_nxt;
    logic [BYTES-1:0]   keep_last_r, keep_last_c;
    logic               final_r, final_nxt, last_nxt;
    logic [31:0]        rem_c, total_c;
    logic [1:0]         fill_mode;
    logic [7:0]         fill_seed;
    logic [31:0]        fill_beat;
    logic [WIDTH-1:0]   fill_data;
    logic               hs;

    assign rem_c       = size % 32'(BYTES);
    assign total_c     = size / 32'(BYTES) + 32'(rem_c != 32'd0);
    assign keep_last_c = BYTES'(keep_mask(rem_c, BYTES));
    assign hs          = tvalid && tready;

    assign beat_nxt    = beat + 32'd1;
    assign final_nxt   = (beat_nxt == total_r - 32'd1);
    assign pkt_cnt_nxt = (pkt_cnt == pkt_len_r) ? PKT_W'(1) : pkt_cnt + PKT_W'(1);
    assign last_nxt    = final_nxt || ((pkt_len_r != '0) && (pkt_cnt_nxt == pkt_len_r));

    // In IDLE the filler sees the live config so beat 0 is ready on the load edge.
    assign fill_mode = (state == IDLE) ? mode : mode_r;
    assign fill_seed = (state == IDLE) ? seed : seed_r;
    assign fill_beat = (state == IDLE) ? 32'd0 : beat_nxt;

    pattern_fill #(.WIDTH(WIDTH)) u_fill (
        .mode (fill_mode),
        .seed (fill_seed),
        .beat (fill_beat),
        .data (fill_data)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // DONE lingers one extra cycle for size 0 so ap_done follows ap_ready.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_start) state_nxt = (size != 32'd0) ? RUN : DONE;
            RUN:     if (hs && final_r) state_nxt = DONE;
            DONE:    if (ap_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_ready    <= 1'b0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            tdata       <= '0;
            tkeep       <= '0;
            tvalid      <= 1'b0;
            tlast       <= 1'b0;
            mode_r      <= '0;
            seed_r      <= '0;
            pkt_len_r   <= '0;
            pkt_cnt     <= '0;
            total_r     <= '0;
            beat        <= '0;
            keep_last_r <= '0;
            final_r     <= 1'b0;
        end else begin
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;
            ap_idle  <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        mode_r      <= mode;
                        seed_r      <= seed;
                        pkt_len_r   <= pkt_len;
                        total_r     <= total_c;
                        keep_last_r <= keep_last_c;
                        beat        <= '0;
                        pkt_cnt     <= PKT_W'(1);
                        ap_ready    <= 1'b1;
                        if (size != 32'd0) begin
                            tvalid  <= 1'b1;
                            tdata   <= fill_data;
                            final_r <= (total_c == 32'd1);
                            tkeep   <= (total_c == 32'd1) ? keep_last_c : '1;
                            tlast   <= (total_c == 32'd1) || (pkt_len == PKT_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (final_r) begin
                            tvalid  <= 1'b0;
                            tlast   <= 1'b0;
                            ap_done <= 1'b1;
                        end else begin
                            beat    <= beat_nxt;
                            pkt_cnt <= pkt_cnt_nxt;
                            tdata   <= fill_data;
                            final_r <= final_nxt;
                            tkeep   <= final_nxt ? keep_last_r : '1;
                            tlast   <= last_nxt;
                        end
                    end
                end
                DONE:    ap_done <= !ap_done;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// tb/tb_stream_pattern_gen.sv - directed self-checking bench for stream_pattern_gen
module tb_stream_pattern_gen;

    localparam int WIDTH = 32;
    localparam int BYTES = 4;
    localparam int PKT_W = 16;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              ap_start = 1'b0;
    logic              ap_ready, ap_done, ap_idle;
    logic [1:0]        mode = '0;
    logic [7:0]        seed = '0;
    logic [31:0]       size = '0;
    logic [PKT_W-1:0]  pkt_len = '0;
    logic [WIDTH-1:0]  tdata;
    logic [BYTES-1:0]  tkeep;
    logic              tvalid, tlast;
    logic              tready = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    stream_pattern_gen #(.WIDTH(WIDTH), .PKT_W(PKT_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .mode     (mode),
        .seed     (seed),
        .size     (size),
        .pkt_len  (pkt_len),
        .tdata    (tdata),
        .tkeep    (tkeep),
        .tvalid   (tvalid),
        .tlast    (tlast),
        .tready   (tready)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  seed;
        logic [31:0] size;
        logic [15:0] pkt;
        int          first;
        int          n;
    } xfer_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    xfer_t xfers[7];
    beat_t beats[32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_idle"},   ap_idle, 1);
        chk({tag, "_ready"},  ap_ready, 0);
        chk({tag, "_done"},   ap_done, 0);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tlast"},  tlast, 0);
        chk({tag, "_tdata"},  tdata, 0);
        chk({tag, "_tkeep"},  tkeep, 0);
    endtask

    task automatic run_xfer(input xfer_t x, input int id);
        int got, cyc;
        mode = x.mode; seed = x.seed; size = x.size; pkt_len = x.pkt;
        tready = 1'b1; ap_start = 1'b1;
        @(negedge ap_clk);
        chk($sformatf("x%0d_ready", id), ap_ready, 1);
        chk($sformatf("x%0d_idle_low", id), ap_idle, 0);
        ap_start = 1'b0;
        got = 0; cyc = 0;
        while (got < x.n && cyc < 100) begin
            if (cyc == 1) chk($sformatf("x%0d_ready_pulse", id), ap_ready, 0);
            if (tvalid) begin
                chk($sformatf("x%0d_b%0d_tdata", id, got), tdata, beats[x.first+got].d);
                chk($sformatf("x%0d_b%0d_tkeep", id, got), tkeep, beats[x.first+got].k);
                chk($sformatf("x%0d_b%0d_tlast", id, got), tlast, beats[x.first+got].l);
                got++;
            end
            @(negedge ap_clk);
            cyc++;
        end
        chk($sformatf("x%0d_beats", id), got, x.n);
        chk($sformatf("x%0d_done", id), ap_done, 1);
        chk($sformatf("x%0d_tvalid_off", id), tvalid, 0);
        @(negedge ap_clk);
        chk($sformatf("x%0d_done_pulse", id), ap_done, 0);
        chk($sformatf("x%0d_idle_back", id), ap_idle, 1);
    endtask

    initial begin
        int hs, cyc;
        logic stalled;
        logic [37:0] held;

        xfers[0] = '{2'd0, 8'h80, 32'd16, 16'd0, 0, 4};
        xfers[1] = '{2'd0, 8'h00, 32'd10, 16'd0, 4, 3};
        xfers[2] = '{2'd1, 8'h5A, 32'd20, 16'd2, 7, 5};
        xfers[3] = '{2'd3, 8'hFE, 32'd7,  16'd1, 12, 2};
        xfers[4] = '{2'd2, 8'h33, 32'd12, 16'd0, 14, 3};
        xfers[5] = '{2'd0, 8'hF0, 32'd5,  16'd3, 17, 2};
        xfers[6] = '{2'd0, 8'h10, 32'd16, 16'd0, 19, 4};

        beats[0]  = '{32'h83828180, 4'hF, 1'b0};
        beats[1]  = '{32'h87868584, 4'hF, 1'b0};
        beats[2]  = '{32'h8B8A8988, 4'hF, 1'b0};
        beats[3]  = '{32'h8F8E8D8C, 4'hF, 1'b1};
        beats[4]  = '{32'h03020100, 4'hF, 1'b0};
        beats[5]  = '{32'h07060504, 4'hF, 1'b0};
        beats[6]  = '{32'h0B0A0908, 4'h3, 1'b1};
        beats[7]  = '{32'h5A5A5A5A, 4'hF, 1'b0};
        beats[8]  = '{32'h5A5A5A5A, 4'hF, 1'b1};
        beats[9]  = '{32'h5A5A5A5A, 4'hF, 1'b0};
        beats[10] = '{32'h5A5A5A5A, 4'hF, 1'b1};
        beats[11] = '{32'h5A5A5A5A, 4'hF, 1'b1};
        beats[12] = '{32'h0100FFFE, 4'hF, 1'b1};
        beats[13] = '{32'h05040302, 4'h7, 1'b1};
        beats[14] = '{32'h00000000, 4'hF, 1'b0};
        beats[15] = '{32'h00000001, 4'hF, 1'b0};
        beats[16] = '{32'h00000002, 4'hF, 1'b1};
        beats[17] = '{32'hF3F2F1F0, 4'hF, 1'b0};
        beats[18] = '{32'hF7F6F5F4, 4'h1, 1'b1};
        beats[19] = '{32'h13121110, 4'hF, 1'b0};
        beats[20] = '{32'h17161514, 4'hF, 1'b0};
        beats[21] = '{32'h1B1A1918, 4'hF, 1'b0};
        beats[22] = '{32'h1F1E1D1C, 4'hF, 1'b1};

        repeat (3) @(negedge ap_clk);
        check_reset_values("por");
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        for (int i = 0; i < 6; i++) run_xfer(xfers[i], i);

        // Random backpressure: outputs must hold through every stall.
        mode = 2'd2; seed = 8'h33; size = 32'd64; pkt_len = '0;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        hs = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (hs < 16 && cyc < 400) begin
            if (stalled) chk("stall_hold", {tvalid, tlast, tkeep, tdata}, held);
            tready = 1'($urandom_range(0, 1));
            if (tvalid && tready) begin
                chk($sformatf("idx_b%0d_tdata", hs), tdata, 32'(hs));
                chk($sformatf("idx_b%0d_tkeep", hs), tkeep, 4'hF);
                chk($sformatf("idx_b%0d_tlast", hs), tlast, (hs == 15));
                hs++;
            end
            stalled = tvalid && !tready;
            held = {tvalid, tlast, tkeep, tdata};
            @(negedge ap_clk);
            cyc++;
        end
        chk("idx_handshakes", hs, 16);
        chk("idx_done", ap_done, 1);
        chk("idx_tvalid_off", tvalid, 0);
        tready = 1'b1;
        @(negedge ap_clk);
        chk("idx_idle_back", ap_idle, 1);

        // Zero-length transfer.
        size = 32'd0; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        chk("z_ready", ap_ready, 1);
        chk("z_done_early", ap_done, 0);
        chk("z_tvalid0", tvalid, 0);
        chk("z_idle_low", ap_idle, 0);
        @(negedge ap_clk);
        chk("z_done", ap_done, 1);
        chk("z_ready_pulse", ap_ready, 0);
        chk("z_tvalid1", tvalid, 0);
        @(negedge ap_clk);
        chk("z_done_pulse", ap_done, 0);
        chk("z_idle_back", ap_idle, 1);
        chk("z_tvalid2", tvalid, 0);

        // Reset after two handshakes, then restart from beat 0.
        mode = 2'd0; seed = 8'h10; size = 32'd16; pkt_len = '0; tready = 1'b1;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        chk("rst_pre_tdata", tdata, 32'h1B1A1918);
        ap_rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        run_xfer(xfers[6], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
